// File: rtl/id_stage_pipe.sv
// Purpose: WISC-16 decode stage with register file, decoder, immediate extender, load-use detector and the ID/EX register.
// Latency: 1 cycle IF/ID -> ID/EX; a load-use hazard inserts exactly one bubble.
// Backpressure: id_stall holds IF/ID on ex_stall or load-use (hazard term masked by flush); ID/EX holds under ex_stall and refreshes held operands from WB.
//
// Ports: clk/rst_n (async active-low); in_valid/in_instr/in_pc from IF/ID; flush, ex_stall from later stages;
//        wb_we/wb_rd/wb_data writeback port; id_stall (comb) to IF/ID; out_* registered ID/EX fields to EX.
module id_stage_pipe #(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 16,
    parameter int  BYPASS   = 1,
    parameter int  R0_ZERO  = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [15:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_stall,
    output logic              out_valid,
    output logic [3:0]        out_op,
    output logic [AW-1:0]     out_rs_idx,
    output logic [AW-1:0]     out_rt_idx,
    output logic [AW-1:0]     out_rd,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write
);

    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ---------------- instruction fields and immediates ----------------
    logic [3:0]        w_op;
    logic [AW-1:0]     w_fd;
    logic [AW-1:0]     w_fs;
    logic [AW-1:0]     w_ft;
    logic [DATA_W-1:0] w_imm4_s;
    logic [DATA_W-1:0] w_imm8_z;
    logic [DATA_W-1:0] w_imm9_s;
    logic [DATA_W-1:0] w_imm12_s;

    assign w_op      = in_instr[15:12];
    assign w_fd      = in_instr[8 +: AW];
    assign w_fs      = in_instr[4 +: AW];
    assign w_ft      = in_instr[0 +: AW];
    assign w_imm4_s  = {{(DATA_W-4){in_instr[3]}}, in_instr[3:0]};
    assign w_imm8_z  = {{(DATA_W-8){1'b0}}, in_instr[7:0]};
    assign w_imm9_s  = {{(DATA_W-9){in_instr[8]}}, in_instr[8:0]};
    assign w_imm12_s = {{(DATA_W-12){in_instr[11]}}, in_instr[11:0]};

    // ---------------- decoder ----------------
    logic [AW-1:0]     w_rs_idx;
    logic [AW-1:0]     w_rt_idx;
    logic [AW-1:0]     w_rd;
    logic              w_rs_used;
    logic              w_rt_used;
    logic              w_reg_write;
    logic              w_mem_read;
    logic              w_mem_write;
    logic [DATA_W-1:0] w_imm;

    // Unused read ports stay at index 0; out_rd is 0 for ops that write nothing.
    always_comb begin
        w_rs_idx    = '0;
        w_rt_idx    = '0;
        w_rd        = '0;
        w_rs_used   = 1'b0;
        w_rt_used   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_imm       = '0;
        case (w_op)
            OP_LW: begin
                w_rs_idx    = w_fs;
                w_rs_used   = 1'b1;
                w_rd        = w_fd;
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
                w_imm       = w_imm4_s;
            end
            OP_SW: begin
                // store data register sits in [11:8] and travels on the rt port
                w_rs_idx    = w_fs;
                w_rs_used   = 1'b1;
                w_rt_idx    = w_fd;
                w_rt_used   = 1'b1;
                w_mem_write = 1'b1;
                w_imm       = w_imm4_s;
            end
            OP_LHB: begin
                // LHB keeps the low byte of rd, so rd is also read on the rt port
                w_rt_idx    = w_fd;
                w_rt_used   = 1'b1;
                w_rd        = w_fd;
                w_reg_write = 1'b1;
                w_imm       = w_imm8_z;
            end
            OP_LLB: begin
                w_rd        = w_fd;
                w_reg_write = 1'b1;
                w_imm       = w_imm8_z;
            end
            OP_BR:   w_imm = w_imm9_s;
            OP_CALL: w_imm = w_imm12_s;
            OP_RET, OP_HALT: begin
                w_imm = '0;
            end
            default: begin
                // ALU ops 0-7
                w_rs_idx    = w_fs;
                w_rs_used   = 1'b1;
                w_rt_idx    = w_ft;
                w_rt_used   = 1'b1;
                w_rd        = w_fd;
                w_reg_write = 1'b1;
                w_imm       = w_imm4_s;
            end
        endcase
    end

    // ---------------- register file ----------------
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wb_wr;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    // With R0_ZERO, R0 is never written and resets to 0, so it always reads 0
    // without any special-case read logic (the bypass also skips R0).
    assign w_wb_wr = wb_we && !((R0_ZERO != 0) && (wb_rd == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wb_wr) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        w_rs_data = r_regs[w_rs_idx];
        w_rt_data = r_regs[w_rt_idx];
        if ((BYPASS != 0) && w_wb_wr) begin
            if (wb_rd == w_rs_idx) w_rs_data = wb_data;
            if (wb_rd == w_rt_idx) w_rt_data = wb_data;
        end
    end

    // ---------------- ID/EX register ----------------
    logic              r_valid;
    logic [3:0]        r_op;
    logic [AW-1:0]     r_rs_idx;
    logic [AW-1:0]     r_rt_idx;
    logic [AW-1:0]     r_rd;
    logic              r_rs_used;
    logic              r_rt_used;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;

    // ---------------- load-use hazard ----------------
    logic w_rd_hit;
    logic w_haz;

    assign w_rd_hit = (w_rs_used && (w_rs_idx == r_rd)) || (w_rt_used && (w_rt_idx == r_rd));
    assign w_haz    = in_valid && r_valid && r_mem_read && w_rd_hit
                      && !((R0_ZERO != 0) && (r_rd == '0));
    assign id_stall = ex_stall || (w_haz && !flush);

    // A held instruction would otherwise miss a WB write that lands while EX is stalled.
    logic w_ref_rs;
    logic w_ref_rt;

    assign w_ref_rs = w_wb_wr && r_rs_used && (wb_rd == r_rs_idx);
    assign w_ref_rt = w_wb_wr && r_rt_used && (wb_rd == r_rt_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_op        <= '0;
            r_rs_idx    <= '0;
            r_rt_idx    <= '0;
            r_rd        <= '0;
            r_rs_used   <= 1'b0;
            r_rt_used   <= 1'b0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (ex_stall) begin
            if (w_ref_rs) r_rs_data <= wb_data;
            if (w_ref_rt) r_rt_data <= wb_data;
        end else if (w_haz) begin
            // bubble; IF/ID is held and re-decoded next cycle
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_valid     <= in_valid;
            r_op        <= w_op;
            r_rs_idx    <= w_rs_idx;
            r_rt_idx    <= w_rt_idx;
            r_rd        <= w_rd;
            r_rs_used   <= w_rs_used;
            r_rt_used   <= w_rt_used;
            r_rs_data   <= w_rs_data;
            r_rt_data   <= w_rt_data;
            r_imm       <= w_imm;
            r_pc        <= in_pc;
            r_reg_write <= w_reg_write && in_valid;
            r_mem_read  <= w_mem_read && in_valid;
            r_mem_write <= w_mem_write && in_valid;
        end
    end

    assign out_valid     = r_valid;
    assign out_op        = r_op;
    assign out_rs_idx    = r_rs_idx;
    assign out_rt_idx    = r_rt_idx;
    assign out_rd        = r_rd;
    assign out_rs_data   = r_rs_data;
    assign out_rt_data   = r_rt_data;
    assign out_imm       = r_imm;
    assign out_pc        = r_pc;
    assign out_reg_write = r_reg_write;
    assign out_mem_read  = r_mem_read;
    assign out_mem_write = r_mem_write;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Purpose: self-checking bench for id_stage_pipe (BYPASS=1 and BYPASS=0 instances side by side).
// Latency: expects ID/EX one cycle after IF/ID, one bubble per load-use hazard.
// Backpressure: bench upstream holds its instruction whenever the expected id_stall is high.
module tb_id_stage_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        flush;
    logic        ex_stall;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;

    typedef struct packed {
        logic        stall;
        logic        v;
        logic [3:0]  op;
        logic [3:0]  rs_idx;
        logic [3:0]  rt_idx;
        logic [3:0]  rd;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic [15:0] pc;
        logic        rw;
        logic        mr;
        logic        mw;
    } obs_t;

    logic        b1_stall, b1_v, b1_rw, b1_mr, b1_mw;
    logic [3:0]  b1_op, b1_rs_idx, b1_rt_idx, b1_rd;
    logic [15:0] b1_rs_data, b1_rt_data, b1_imm, b1_pc;
    logic        b0_stall, b0_v, b0_rw, b0_mr, b0_mw;
    logic [3:0]  b0_op, b0_rs_idx, b0_rt_idx, b0_rd;
    logic [15:0] b0_rs_data, b0_rt_data, b0_imm, b0_pc;
    obs_t        obs1;
    obs_t        obs0;

    assign obs1 = {b1_stall, b1_v, b1_op, b1_rs_idx, b1_rt_idx, b1_rd,
                   b1_rs_data, b1_rt_data, b1_imm, b1_pc, b1_rw, b1_mr, b1_mw};
    assign obs0 = {b0_stall, b0_v, b0_op, b0_rs_idx, b0_rt_idx, b0_rd,
                   b0_rs_data, b0_rt_data, b0_imm, b0_pc, b0_rw, b0_mr, b0_mw};

    id_stage_pipe #(.DATA_W(16), .NUM_REGS(16), .BYPASS(1), .R0_ZERO(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .ex_stall(ex_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_stall(b1_stall), .out_valid(b1_v), .out_op(b1_op), .out_rs_idx(b1_rs_idx),
        .out_rt_idx(b1_rt_idx), .out_rd(b1_rd), .out_rs_data(b1_rs_data), .out_rt_data(b1_rt_data),
        .out_imm(b1_imm), .out_pc(b1_pc), .out_reg_write(b1_rw), .out_mem_read(b1_mr),
        .out_mem_write(b1_mw)
    );

    id_stage_pipe #(.DATA_W(16), .NUM_REGS(16), .BYPASS(0), .R0_ZERO(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .ex_stall(ex_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_stall(b0_stall), .out_valid(b0_v), .out_op(b0_op), .out_rs_idx(b0_rs_idx),
        .out_rt_idx(b0_rt_idx), .out_rd(b0_rd), .out_rs_data(b0_rs_data), .out_rt_data(b0_rt_data),
        .out_imm(b0_imm), .out_pc(b0_pc), .out_reg_write(b0_rw), .out_mem_read(b0_mr),
        .out_mem_write(b0_mw)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [3:0]  rs_idx;
        logic [3:0]  rt_idx;
        logic [3:0]  rd;
        logic        rs_used;
        logic        rt_used;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic [15:0] pc;
        logic        rw;
        logic        mr;
        logic        mw;
    } ref_t;

    ref_t        m_ex [2];
    logic [15:0] m_regs [16];
    logic        m_last_stall;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) m_ex[b] = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_last_stall = 1'b0;
    endtask

    function automatic logic [15:0] sx(input int val, input int bits);
        int r;
        r = (val >= (1 << (bits - 1))) ? val - (1 << bits) : val;
        return 16'(r);
    endfunction

    function automatic logic [15:0] rd_reg(input logic [3:0] idx, input int byp);
        if (idx == 4'd0) return 16'h0000;
        if (byp != 0 && wb_we && wb_rd == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic ref_t decode(input int byp);
        ref_t d;
        logic [3:0] op, fd, fs, ft;
        d  = '0;
        op = in_instr[15:12];
        fd = in_instr[11:8];
        fs = in_instr[7:4];
        ft = in_instr[3:0];
        d.v  = in_valid;
        d.op = op;
        d.pc = in_pc;
        if (op < 4'd8) begin
            d.rs_idx = fs; d.rs_used = 1'b1; d.rt_idx = ft; d.rt_used = 1'b1;
            d.rd = fd; d.rw = 1'b1; d.imm = sx(int'(ft), 4);
        end else if (op == 4'h8) begin
            d.rs_idx = fs; d.rs_used = 1'b1; d.rd = fd; d.rw = 1'b1; d.mr = 1'b1;
            d.imm = sx(int'(ft), 4);
        end else if (op == 4'h9) begin
            d.rs_idx = fs; d.rs_used = 1'b1; d.rt_idx = fd; d.rt_used = 1'b1; d.mw = 1'b1;
            d.imm = sx(int'(ft), 4);
        end else if (op == 4'hA) begin
            d.rt_idx = fd; d.rt_used = 1'b1; d.rd = fd; d.rw = 1'b1;
            d.imm = {8'h00, in_instr[7:0]};
        end else if (op == 4'hB) begin
            d.rd = fd; d.rw = 1'b1; d.imm = {8'h00, in_instr[7:0]};
        end else if (op == 4'hC) begin
            d.imm = sx(int'(in_instr[8:0]), 9);
        end else if (op == 4'hD) begin
            d.imm = sx(int'(in_instr[11:0]), 12);
        end
        if (!in_valid) begin
            d.rw = 1'b0; d.mr = 1'b0; d.mw = 1'b0;
        end
        d.rs_data = rd_reg(d.rs_idx, byp);
        d.rt_data = rd_reg(d.rt_idx, byp);
        return d;
    endfunction

    task automatic cmp_dut(input int b);
        obs_t  o;
        ref_t  m;
        string t;
        o = (b == 1) ? obs1 : obs0;
        m = m_ex[b];
        t = (b == 1) ? "byp1" : "byp0";
        check({t, " out_valid"}, 32'(o.v), 32'(m.v));
        if (m.v) begin
            check({t, " out_op"}, 32'(o.op), 32'(m.op));
            check({t, " out_rs_idx"}, 32'(o.rs_idx), 32'(m.rs_idx));
            check({t, " out_rt_idx"}, 32'(o.rt_idx), 32'(m.rt_idx));
            check({t, " out_rd"}, 32'(o.rd), 32'(m.rd));
            check({t, " out_rs_data"}, 32'(o.rs_data), 32'(m.rs_data));
            check({t, " out_rt_data"}, 32'(o.rt_data), 32'(m.rt_data));
            check({t, " out_imm"}, 32'(o.imm), 32'(m.imm));
            check({t, " out_pc"}, 32'(o.pc), 32'(m.pc));
            check({t, " out_reg_write"}, 32'(o.rw), 32'(m.rw));
            check({t, " out_mem_read"}, 32'(o.mr), 32'(m.mr));
            check({t, " out_mem_write"}, 32'(o.mw), 32'(m.mw));
        end
    endtask

    // Checks id_stall for the applied inputs, advances the model, clocks, compares.
    task automatic tick();
        ref_t d [2];
        logic haz;
        logic exp_stall;
        for (int b = 0; b < 2; b++) d[b] = decode(b);
        haz = in_valid && m_ex[1].v && m_ex[1].mr && (m_ex[1].rd != 4'd0) &&
              ((d[1].rs_used && d[1].rs_idx == m_ex[1].rd) ||
               (d[1].rt_used && d[1].rt_idx == m_ex[1].rd));
        exp_stall = ex_stall || (haz && !flush);
        check("byp1 id_stall", 32'(obs1.stall), 32'(exp_stall));
        check("byp0 id_stall", 32'(obs0.stall), 32'(exp_stall));
        m_last_stall = exp_stall;
        for (int b = 0; b < 2; b++) begin
            if (flush) begin
                m_ex[b].v = 1'b0;
            end else if (ex_stall) begin
                if (wb_we && wb_rd != 4'd0) begin
                    if (m_ex[b].rs_used && m_ex[b].rs_idx == wb_rd) m_ex[b].rs_data = wb_data;
                    if (m_ex[b].rt_used && m_ex[b].rt_idx == wb_rd) m_ex[b].rt_data = wb_data;
                end
            end else if (haz) begin
                m_ex[b].v = 1'b0;
            end else begin
                m_ex[b] = d[b];
            end
        end
        if (wb_we && wb_rd != 4'd0) m_regs[wb_rd] = wb_data;
        @(posedge clk);
        #1;
        cmp_dut(1);
        cmp_dut(0);
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic fl, input logic st,
                         input logic we, input logic [3:0] rd, input logic [15:0] dat);
        in_valid = v;
        in_instr = ins;
        in_pc    = 16'($urandom);
        flush    = fl;
        ex_stall = st;
        wb_we    = we;
        wb_rd    = rd;
        wb_data  = dat;
        #1;
    endtask

    // ---------------- decode / immediate vectors ----------------
    typedef struct {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [15:0] p0;
        logic [15:0] r_instr;
        logic        r_valid;
        logic        r_flush;

        vt[0]  = '{16'h912F, 16'hFFFF, 4'd2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1}; // SW imm4=F
        vt[1]  = '{16'hB3F0, 16'h00F0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0}; // LLB
        vt[2]  = '{16'hC100, 16'hFF00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}; // branch 0x100
        vt[3]  = '{16'hD800, 16'hF800, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}; // call 0x800
        vt[4]  = '{16'h8A37, 16'h0007, 4'd3, 4'd0, 4'hA, 1'b1, 1'b1, 1'b0}; // LW
        vt[5]  = '{16'hA5C3, 16'h00C3, 4'd0, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0}; // LHB
        vt[6]  = '{16'h7ABC, 16'hFFFC, 4'hB, 4'hC, 4'hA, 1'b1, 1'b0, 1'b0}; // ALU op7
        vt[7]  = '{16'hE123, 16'h0000, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}; // ret
        vt[8]  = '{16'hF0FF, 16'h0000, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}; // halt
        vt[9]  = '{16'hC0FF, 16'h00FF, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}; // branch positive
        vt[10] = '{16'h3458, 16'hFFF8, 4'd5, 4'd8, 4'd4, 1'b1, 1'b0, 1'b0}; // ALU op3

        // ---- reset ----
        rst_n = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; ex_stall = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(obs1.v), 32'd0);
        check("reset out_rs_data", 32'(obs1.rs_data), 32'd0);
        check("reset out_pc", 32'(obs1.pc), 32'd0);
        check("reset out_imm", 32'(obs1.imm), 32'd0);
        check("reset out_reg_write", 32'(obs1.rw), 32'd0);
        check("reset byp0 out_valid", 32'(obs0.v), 32'd0);
        rst_n = 1'b1;

        // ---- reset then load ----
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd3, 16'h1234); tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd4, 16'h0010); tick();
        drive(1'b1, 16'h0534, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();
        check("add out_valid", 32'(obs1.v), 32'd1);
        check("add rs_data", 32'(obs1.rs_data), 32'h1234);
        check("add rt_data", 32'(obs1.rt_data), 32'h0010);
        check("add rd", 32'(obs1.rd), 32'd5);
        check("add reg_write", 32'(obs1.rw), 32'd1);

        // ---- bypass ----
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd7, 16'h1111); tick();
        drive(1'b1, 16'h1177, 1'b0, 1'b0, 1'b1, 4'd7, 16'hBEEF); tick();
        check("bypass1 rs_data", 32'(obs1.rs_data), 32'hBEEF);
        check("bypass1 rt_data", 32'(obs1.rt_data), 32'hBEEF);
        check("bypass0 rs_data", 32'(obs0.rs_data), 32'h1111);
        check("bypass0 rt_data", 32'(obs0.rt_data), 32'h1111);
        drive(1'b1, 16'h1177, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();
        check("after write byp0 rs_data", 32'(obs0.rs_data), 32'hBEEF);

        // ---- load-use ----
        drive(1'b1, 16'h8214, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();
        check("lw mem_read", 32'(obs1.mr), 32'd1);
        drive(1'b1, 16'h0623, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
        check("load-use id_stall", 32'(obs1.stall), 32'd1);
        tick();
        check("load-use bubble", 32'(obs1.v), 32'd0);
        drive(1'b1, 16'h0623, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
        check("load-use released", 32'(obs1.stall), 32'd0);
        tick();
        check("load-use add valid", 32'(obs1.v), 32'd1);
        check("load-use add rd", 32'(obs1.rd), 32'd6);
        check("load-use add rs_idx", 32'(obs1.rs_idx), 32'd2);
        drive(1'b1, 16'h8014, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();
        drive(1'b1, 16'h0603, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
        check("lw r0 no stall", 32'(obs1.stall), 32'd0);
        tick();
        check("lw r0 use valid", 32'(obs1.v), 32'd1);

        // ---- hold-refresh ----
        drive(1'b1, 16'h0534, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
        p0 = in_pc;
        tick();
        drive(1'b1, 16'h0534, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000);
        check("ex_stall id_stall", 32'(obs1.stall), 32'd1);
        tick();
        drive(1'b1, 16'h0534, 1'b0, 1'b1, 1'b1, 4'd4, 16'h0AAA); tick();
        drive(1'b1, 16'h0534, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000); tick();
        check("refresh rt_data", 32'(obs1.rt_data), 32'h0AAA);
        check("refresh rs_data", 32'(obs1.rs_data), 32'h1234);
        check("refresh rd", 32'(obs1.rd), 32'd5);
        check("refresh pc", 32'(obs1.pc), 32'(p0));
        check("refresh valid", 32'(obs1.v), 32'd1);
        check("refresh byp0 rt_data", 32'(obs0.rt_data), 32'h0AAA);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();

        // ---- flush priority ----
        drive(1'b1, 16'h8214, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();
        drive(1'b1, 16'h0623, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000); tick();
        check("flush+stall+haz valid", 32'(obs1.v), 32'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
        check("flush+stall+haz id_stall after", 32'(obs1.stall), 32'd0);
        tick();
        drive(1'b1, 16'h8214, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();
        drive(1'b1, 16'h0623, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
        check("flush+haz id_stall", 32'(obs1.stall), 32'd0);
        tick();
        check("flush+haz valid", 32'(obs1.v), 32'd0);

        // ---- decode / immediate table ----
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();
            drive(1'b1, vt[i].instr, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();
            check($sformatf("vec%0d imm", i), 32'(obs1.imm), 32'(vt[i].imm));
            check($sformatf("vec%0d op", i), 32'(obs1.op), 32'(vt[i].instr[15:12]));
            check($sformatf("vec%0d rs_idx", i), 32'(obs1.rs_idx), 32'(vt[i].rs));
            check($sformatf("vec%0d rt_idx", i), 32'(obs1.rt_idx), 32'(vt[i].rt));
            check($sformatf("vec%0d rd", i), 32'(obs1.rd), 32'(vt[i].rd));
            check($sformatf("vec%0d ctrl", i), 32'({obs1.rw, obs1.mr, obs1.mw}),
                  32'({vt[i].rw, vt[i].mr, vt[i].mw}));
        end

        // ---- R0 stays zero ----
        drive(1'b1, 16'h0100, 1'b0, 1'b0, 1'b1, 4'd0, 16'h5555); tick();
        check("r0 same-cycle rs", 32'(obs1.rs_data), 32'd0);
        check("r0 same-cycle rt", 32'(obs1.rt_data), 32'd0);
        drive(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();
        check("r0 after write rs", 32'(obs1.rs_data), 32'd0);

        // ---- randomized run against the model ----
        r_instr = 16'h0000;
        r_valid = 1'b0;
        r_flush = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic [3:0] op;
            if (!(m_last_stall && !r_flush)) begin
                op = ($urandom_range(0, 3) == 0) ? 4'h8 : 4'($urandom_range(0, 15));
                r_instr = {op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                           4'($urandom_range(0, 15))};
                r_valid = ($urandom_range(0, 4) != 0);
            end
            r_flush = ($urandom_range(0, 11) == 0);
            drive(r_valid, r_instr, r_flush, ($urandom_range(0, 6) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom));
            tick();
        end

        // ---- reset during a stall discards everything ----
        drive(1'b1, 16'h0534, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();
        drive(1'b1, 16'h0534, 1'b0, 1'b1, 1'b1, 4'd3, 16'h7777);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(obs1.v), 32'd0);
        check("async reset out_pc", 32'(obs1.pc), 32'd0);
        check("async reset byp0 out_valid", 32'(obs0.v), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 16'h0534, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000); tick();
        check("post-reset rs_data", 32'(obs1.rs_data), 32'd0);
        check("post-reset rt_data", 32'(obs1.rt_data), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised successor decode stage for the WISC 16-bit pipeline.
- Contains the register file, decoder/control, immediate extender, load-use hazard detector and the registered ID/EX pipeline boundary.
- Adds a valid/stall/flush handshake, WB-to-ID write-through bypass, and refresh of held operands, which the previous decode unit lacked.
- Sits between the IF/ID register (upstream) and the EX stage (downstream).

Parameters:
- DATA_W, 16: datapath, register and PC width (>=16).
- NUM_REGS, 16: register count, 2..16. Register fields use the low AW=$clog2(NUM_REGS) bits of each 4-bit instruction field.
- BYPASS, 1: 1 = a register-file read of a register being written this cycle returns wb_data.
- R0_ZERO, 1: 1 = R0 reads as 0, writes to R0 are ignored, and R0 never causes a hazard.

Ports:
- clk, in, 1: the one clock; all state updates on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: IF/ID holds a real instruction.
- in_instr, in, 16: fields [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
- in_pc, in, DATA_W: PC of in_instr.
- flush, in, 1: squash (branch/call/ret resolved in a later stage).
- ex_stall, in, 1: EX cannot accept a new instruction.
- wb_we, in, 1: writeback write enable.
- wb_rd, in, AW: writeback register index.
- wb_data, in, DATA_W: writeback data.
- id_stall, out, 1: IF/ID must hold (comb).
- out_valid, out, 1: ID/EX register holds a real instruction.
- out_op, out, 4: latched opcode.
- out_rs_idx, out, AW: latched source-1 index, for EX forwarding.
- out_rt_idx, out, AW: latched source-2 index, for EX forwarding.
- out_rd, out, AW: latched destination index.
- out_rs_data, out, DATA_W: source-1 operand.
- out_rt_data, out, DATA_W: source-2 operand.
- out_imm, out, DATA_W: extended immediate.
- out_pc, out, DATA_W: latched PC.
- out_reg_write, out, 1: control bit.
- out_mem_read, out, 1: control bit.
- out_mem_write, out, 1: control bit.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All ID/EX outputs are 0, including out_valid.
  - All registers are 0.
  - Asserting rst_n mid-stall or mid-flush discards everything; no transaction survives reset.
- Decode, by op:
  - 0-7 (ALU): reads rs,rt; writes rd; imm = sext(imm4).
  - 8 (LW): reads rs; writes rd; mem_read; imm = sext(imm4).
  - 9 (SW): reads rs and [11:8]; the [11:8] read goes to the rt port and out_rt_idx; mem_write; imm = sext(imm4).
  - A (LHB): reads [11:8] on the rt port; writes rd; imm = zext([7:0]).
  - B (LLB): writes rd; imm = zext([7:0]).
  - C (branch): imm = sext([8:0]).
  - D (call): imm = sext([11:0]).
  - E (ret), F (halt): no register reads or writes; imm = 0.
  - Unused read ports return index 0.
- Register file:
  - Synchronous write on the clk edge when wb_we is high and not (R0_ZERO and wb_rd==0).
  - Combinational read.
  - When BYPASS=1 and wb_we is high with a matching, writable wb_rd, the read returns wb_data in the same cycle.
- Load-use hazard (comb):
  - haz = in_valid & out_valid & out_mem_read & out_rd is a used source of in_instr.
  - R0 is excluded when R0_ZERO=1.
  - id_stall = ex_stall | (haz & ~flush).
- ID/EX update, evaluated in priority order at each clk edge:
  1. flush: out_valid <= 0; other fields don't-care. flush overrides ex_stall.
  2. ex_stall: hold all fields. If wb_we writes a register matching a held, used out_rs_idx/out_rt_idx, replace that held operand with wb_data.
  3. haz: out_valid <= 0 (bubble); IF/ID holds via id_stall. The next cycle re-evaluates haz.
  4. Otherwise: load decoded fields, with out_valid <= in_valid. Control bits are forced to 0 when in_valid=0.
- Latency: 1 cycle from IF/ID to ID/EX. A load-use hazard costs exactly 1 bubble.
- A flush and a hazard in the same cycle: flush wins and id_stall is low from the hazard term.
- Simultaneous WB write and ID read of the same register: BYPASS=1 returns the new value; BYPASS=0 returns the old value.

Test Plan:
- Reset then load: rst_n low for 2 cycles, then write R3=0x1234 and R4=0x0010, then issue ADD R5,R3,R4 (0x0534). Next cycle: out_valid=1, rs_data=0x1234, rt_data=0x0010, rd=5, reg_write=1.
- Load-use: LW R2,R1,4 (0x8214) followed by ADD R6,R2,R3 (0x0623). id_stall=1 for one cycle, then a bubble (out_valid=0), then the ADD appears. LW R0 followed by a use of R0 causes no stall when R0_ZERO=1.
- Bypass: wb_we=1, wb_rd=7, wb_data=0xBEEF while SUB R1,R7,R7 is in ID. Both operands=0xBEEF with BYPASS=1; old value with BYPASS=0.
- Hold-refresh: ex_stall for 3 cycles with ADD R5,R3,R4 held, while WB writes R4=0x0AAA in cycle 2. out_rt_data becomes 0x0AAA and all other fields are unchanged.
- Flush priority: flush=1, ex_stall=1 and a hazard all in the same cycle. Next cycle: out_valid=0 and id_stall deasserts.
- Immediates: SW with imm4=0xF gives out_imm=0xFFFF. LLB 0xB3F0 gives out_imm=0x00F0. Branch [8:0]=0x100 gives 0xFF00. Call [11:0]=0x800 gives 0xF800. R0 write with R0_ZERO=1 still reads 0.
